sc_core_oz_rf_reader: RTL and testbench

Read side of the single-cycle core register file. It holds the 31 writable GPRs; x0 is hard-wired to zero.
- Writes arrive from writeback on the rd_reg_* port.
- Two combinational read ports (rs1/rs2) serve decode/execute, with same-cycle write bypass.
- A debug dump engine streams all 32 registers, x0..x31, over a valid/ready handshake for post-test comparison.

---
 rtl/sc_core_oz_pkg.sv | 31 +++
 rtl/sc_core_oz_rf_reader_if.sv | 28 ++
 rtl/sc_core_oz_rf_dump.sv | 91 +++++++++
 rtl/sc_core_oz_rf_reader.sv | 59 +++++
 tb/tb_sc_core_oz_rf_reader.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sc_core_oz_pkg.sv
// Shared types, sizes and the bypass helper
// for the core register file read side.
package sc_core_oz_pkg;

  localparam int NUM_REGS = 32;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DONE
  } t_rf_dump_state;

  function automatic logic [DATA_W-1:0] rf_bypass(
    input logic              wr_en,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [DATA_W-1:0] wr_data,
    input logic [ADDR_W-1:0] rd_addr,
    input logic [DATA_W-1:0] stored
  );
    if (rd_addr == '0)
      return '0;
    else if (wr_en && (wr_addr == rd_addr))
      return wr_data;
    else
      return stored;
  endfunction

endpackage

// File: rtl/sc_core_oz_rf_reader_if.sv
// Register dump stream: one beat per
// register, valid/ready handshake.
interface sc_core_oz_rf_reader_if;
  import sc_core_oz_pkg::*;

  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_idx;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;

  modport master (
    output dump_valid,
    output dump_idx,
    output dump_data,
    output dump_last,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_idx,
    input  dump_data,
    input  dump_last,
    output dump_ready
  );

endinterface

// File: rtl/sc_core_oz_rf_dump.sv
// Dump engine: walks x0..x31 and streams
// a snapshot of each one as a beat.
module sc_core_oz_rf_dump
  import sc_core_oz_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              dump_req,
  output logic [ADDR_W-1:0] rd_idx,
  input  logic [DATA_W-1:0] rd_val,
  output logic              dump_busy,
  output logic              dump_done,
  sc_core_oz_rf_reader_if.master dump
);

  localparam logic [ADDR_W-1:0] LAST_IDX =
    ADDR_W'(NUM_REGS - 1);

  t_rf_dump_state    state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;

  // State, counter and beat output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  // Next state; rd_idx picks the register
  // captured into the beat this cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    data_d  = data_q;
    rd_idx  = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (dump_req) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        idx_d   = cnt_q;
        data_d  = rd_val;
        valid_d = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (valid_q && dump.dump_ready) begin
          if (cnt_q != LAST_IDX) begin
            rd_idx = cnt_q + ADDR_W'(1);
            cnt_d  = rd_idx;
            idx_d  = rd_idx;
            data_d = rd_val;
          end else begin
            valid_d = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign dump_busy       = (state_q != S_IDLE);
  assign dump_done       = (state_q == S_DONE);
  assign dump.dump_valid = valid_q;
  assign dump.dump_idx   = idx_q;
  assign dump.dump_data  = data_q;
  assign dump.dump_last  =
    valid_q && (idx_q == LAST_IDX);

endmodule

// File: rtl/sc_core_oz_rf_reader.sv
// GPR storage with two bypassed read ports
// and a debug dump stream.
module sc_core_oz_rf_reader
  import sc_core_oz_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_reg_wr_en,
  input  logic [ADDR_W-1:0] rd_reg_address,
  input  logic [DATA_W-1:0] rd_reg_data,
  input  logic [ADDR_W-1:0] rs1_address,
  input  logic [ADDR_W-1:0] rs2_address,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              dump_req,
  output logic              dump_busy,
  output logic              dump_done,
  sc_core_oz_rf_reader_if.master dump
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [ADDR_W-1:0] dump_rd_idx;
  logic [DATA_W-1:0] dump_rd_val;

  // Writeback; entry 0 is never written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= '0;
    end else if (rd_reg_wr_en &&
                 (rd_reg_address != '0)) begin
      regs_q[rd_reg_address] <= rd_reg_data;
    end
  end

  assign rs1_data = rf_bypass(
    rd_reg_wr_en, rd_reg_address, rd_reg_data,
    rs1_address, regs_q[rs1_address]);

  assign rs2_data = rf_bypass(
    rd_reg_wr_en, rd_reg_address, rd_reg_data,
    rs2_address, regs_q[rs2_address]);

  assign dump_rd_val = rf_bypass(
    rd_reg_wr_en, rd_reg_address, rd_reg_data,
    dump_rd_idx, regs_q[dump_rd_idx]);

  sc_core_oz_rf_dump u_dump (
    .clk       (clk),
    .rst       (rst),
    .dump_req  (dump_req),
    .rd_idx    (dump_rd_idx),
    .rd_val    (dump_rd_val),
    .dump_busy (dump_busy),
    .dump_done (dump_done),
    .dump      (dump)
  );

endmodule

// File: tb/tb_sc_core_oz_rf_reader.sv
// Bench for the register file read side:
// cycle model plus directed literal checks.
module tb_sc_core_oz_rf_reader;
  import sc_core_oz_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_reg_wr_en = 1'b0;
  logic [4:0]  rd_reg_address = '0;
  logic [31:0] rd_reg_data = '0;
  logic [4:0]  rs1_address = '0;
  logic [4:0]  rs2_address = '0;
  logic [31:0] rs1_data, rs2_data;
  logic        dump_req = 1'b0;
  logic        dump_busy, dump_done;

  sc_core_oz_rf_reader_if dif ();

  sc_core_oz_rf_reader dut (
    .clk            (clk),
    .rst            (rst),
    .rd_reg_wr_en   (rd_reg_wr_en),
    .rd_reg_address (rd_reg_address),
    .rd_reg_data    (rd_reg_data),
    .rs1_address    (rs1_address),
    .rs2_address    (rs2_address),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .dump_req       (dump_req),
    .dump_busy      (dump_busy),
    .dump_done      (dump_done),
    .dump           (dif)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s actual=%h required=%h",
                  nm, act, exp);
  endtask

  // Reference model: architectural registers
  // plus a phase-based view of the dump.
  logic [31:0] m_regs [32];
  int          m_ph  = 0;
  int          m_cnt = 0;
  logic        m_valid = 1'b0;
  logic [4:0]  m_idx = '0;
  logic [31:0] m_data = '0;

  function automatic logic [31:0] m_read(
    input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (rd_reg_wr_en && rd_reg_address == a)
      return rd_reg_data;
    return m_regs[a];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_ph = 0; m_cnt = 0;
      m_valid = 1'b0; m_idx = '0; m_data = '0;
    end else begin
      case (m_ph)
        0: if (dump_req) begin
          m_ph = 1; m_cnt = 0;
        end
        1: begin
          m_idx = 5'(m_cnt);
          m_data = m_read(5'(m_cnt));
          m_valid = 1'b1; m_ph = 2;
        end
        2: if (dif.dump_ready) begin
          if (m_cnt < 31) begin
            m_cnt++;
            m_idx = 5'(m_cnt);
            m_data = m_read(5'(m_cnt));
          end else begin
            m_valid = 1'b0; m_ph = 3;
          end
        end
        default: m_ph = 0;
      endcase
      if (rd_reg_wr_en && rd_reg_address != 5'd0)
        m_regs[rd_reg_address] = rd_reg_data;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rs1_data", rs1_data, m_read(rs1_address));
      chk("rs2_data", rs2_data, m_read(rs2_address));
      chk("busy", 32'(dump_busy), 32'(m_ph != 0));
      chk("done", 32'(dump_done), 32'(m_ph == 3));
      chk("valid", 32'(dif.dump_valid), 32'(m_valid));
      chk("last", 32'(dif.dump_last),
          32'(m_valid && m_idx == 5'd31));
      if (m_valid) begin
        chk("idx", 32'(dif.dump_idx), 32'(m_idx));
        chk("data", dif.dump_data, m_data);
      end
    end
  end

  // Accepted-beat log for literal checks
  logic [4:0]  q_idx [$];
  logic [31:0] q_dat [$];
  always @(negedge clk) begin
    if (rst && dif.dump_valid && dif.dump_ready) begin
      q_idx.push_back(dif.dump_idx);
      q_dat.push_back(dif.dump_data);
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [4:0] a,
                    input logic [31:0] d);
    rd_reg_wr_en = 1'b1;
    rd_reg_address = a;
    rd_reg_data = d;
    tick();
    rd_reg_wr_en = 1'b0;
  endtask

  task automatic start_dump;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
  endtask

  task automatic wait_beat(input logic [4:0] i,
                           input string nm);
    bit ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (dif.dump_valid && dif.dump_idx == i) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input string nm);
    bit ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (dump_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  initial begin
    dif.dump_ready = 1'b1;
    #2 rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    chk_en = 1'b1;

    // Reset state
    rs1_address = 5'd5;
    rs2_address = 5'd0;
    @(negedge clk);
    chk("rst_rs1", rs1_data, 32'd0);
    chk("rst_rs2", rs2_data, 32'd0);
    chk("rst_valid", 32'(dif.dump_valid), 32'd0);
    chk("rst_busy", 32'(dump_busy), 32'd0);
    chk("rst_last", 32'(dif.dump_last), 32'd0);
    chk("rst_done", 32'(dump_done), 32'd0);
    chk("rst_idx", 32'(dif.dump_idx), 32'd0);
    chk("rst_data", dif.dump_data, 32'd0);
    tick();

    // Same-cycle bypass, then x0 write
    rs1_address = 5'd7;
    rd_reg_wr_en = 1'b1;
    rd_reg_address = 5'd7;
    rd_reg_data = 32'hDEADBEEF;
    #2 chk("bypass_x7", rs1_data, 32'hDEADBEEF);
    tick();
    rd_reg_address = 5'd0;
    rd_reg_data = 32'h1234;
    #2 chk("x0_wr_read", rs2_data, 32'd0);
    tick();
    rd_reg_wr_en = 1'b0;
    #2 chk("x0_after", rs2_data, 32'd0);
    chk("x7_stored", rs1_data, 32'hDEADBEEF);

    // Full dump under continuous ready
    for (int n = 1; n < 32; n++)
      wr(5'(n), 32'h100 + 32'(n));
    q_idx.delete(); q_dat.delete();
    start_dump();
    wait_done("full_done_timeout");
    chk("full_beats", 32'(q_idx.size()), 32'd32);
    for (int i = 0; i < 32 && i < q_idx.size(); i++) begin
      chk("full_idx", 32'(q_idx[i]), 32'(i));
      chk("full_data", q_dat[i],
          (i == 0) ? 32'd0 : 32'h100 + 32'(i));
    end
    @(negedge clk);
    chk("busy_after_done", 32'(dump_busy), 32'd0);
    chk("done_one_cycle", 32'(dump_done), 32'd0);
    tick();

    // Backpressure hold at idx 4
    start_dump();
    wait_beat(5'd4, "bp_wait_timeout");
    dif.dump_ready = 1'b0;
    rd_reg_wr_en = 1'b1;
    rd_reg_address = 5'd4;
    rd_reg_data = 32'hAAAA;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_idx", 32'(dif.dump_idx), 32'd4);
      chk("bp_data", dif.dump_data, 32'h104);
      tick();
      rd_reg_wr_en = 1'b0;
    end
    dif.dump_ready = 1'b1;
    wait_done("bp_done_timeout");
    tick();
    q_idx.delete(); q_dat.delete();
    start_dump();
    wait_done("redump_timeout");
    chk("redump_beats", 32'(q_idx.size()), 32'd32);
    if (q_idx.size() > 4) begin
      chk("redump_idx4", 32'(q_idx[4]), 32'd4);
      chk("redump_x4", q_dat[4], 32'hAAAA);
    end
    tick();

    // Write during load, ignored second request
    start_dump();
    wait_beat(5'd1, "ld_wait_timeout");
    rd_reg_wr_en = 1'b1;
    rd_reg_address = 5'd2;
    rd_reg_data = 32'h55;
    dump_req = 1'b1;
    tick();
    rd_reg_wr_en = 1'b0;
    dump_req = 1'b0;
    chk("ld_idx2", 32'(dif.dump_idx), 32'd2);
    chk("ld_data2", dif.dump_data, 32'h55);
    wait_done("ld_done_timeout");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("no_restart", 32'(dump_busy), 32'd0);
    end
    tick();

    // Reset in the middle of a dump
    rs1_address = 5'd7;
    start_dump();
    wait_beat(5'd10, "mid_wait_timeout");
    #1 rst = 1'b0;
    #1;
    chk("mid_valid", 32'(dif.dump_valid), 32'd0);
    chk("mid_busy", 32'(dump_busy), 32'd0);
    chk("mid_done", 32'(dump_done), 32'd0);
    chk("mid_rs1", rs1_data, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    start_dump();
    for (int k = 0; k < 10 && !dif.dump_valid; k++)
      tick();
    chk("restart_valid", 32'(dif.dump_valid), 32'd1);
    chk("restart_idx", 32'(dif.dump_idx), 32'd0);
    wait_done("restart_done_timeout");
    tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
